// File: rtl/vram_dma_writer.sv
// VRAM write initiator: streams bytes into GPU VRAM during vertical blank.
// One-deep holding register lets accept and write overlap at one byte/cycle.
module vram_dma_writer #(
  parameter int VRAM_ADDR_WIDTH = 12
) (
  input  logic                       clk_12_5875,
  input  logic                       rst,
  input  logic                       start,
  input  logic [VRAM_ADDR_WIDTH-1:0] start_addr,
  input  logic [VRAM_ADDR_WIDTH:0]   length,
  input  logic [7:0]                 s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic                       vblank,
  output logic [7:0]                 data,
  output logic [VRAM_ADDR_WIDTH-1:0] address,
  output logic                       cs,
  output logic                       busy,
  output logic                       done
);

  localparam int AW = VRAM_ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DONE
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [AW-1:0] cur_addr;
  logic [AW:0]   remaining;
  logic          pend;
  logic          accept;

  assign s_ready = (state_q == XFER) && (remaining != '0)
                && (!pend || vblank);
  assign cs      = pend && vblank;
  assign accept  = s_valid && s_ready;
  assign busy    = (state_q == XFER);
  assign done    = (state_q == DONE);

  // Leave XFER as the final held byte is written, so done trails the last cs.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = XFER;
      XFER: if ((remaining == '0) && (!pend || vblank)) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_12_5875 or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      pend      <= 1'b0;
      data      <= '0;
      address   <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && start) begin
        cur_addr  <= start_addr;
        remaining <= length;
      end
      if (accept) begin
        data      <= s_data;
        address   <= cur_addr;
        pend      <= 1'b1;
        cur_addr  <= cur_addr + AW'(1);
        remaining <= remaining - (AW+1)'(1);
      end else if (cs) begin
        pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vram_dma_writer.sv
// Directed bench for vram_dma_writer.
// Inputs change 1ns after posedge; outputs are checked at negedge.
module tb_vram_dma_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] start_addr;
  logic [12:0] length;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic        vblank;
  logic [7:0]  data;
  logic [11:0] address;
  logic        cs;
  logic        busy;
  logic        done;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  vram_dma_writer #(.VRAM_ADDR_WIDTH(12)) dut (
    .clk_12_5875(clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .length     (length),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .vblank     (vblank),
    .data       (data),
    .address    (address),
    .cs         (cs),
    .busy       (busy),
    .done       (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ctl(input string tag, input logic e_rdy,
                         input logic e_cs, input logic e_busy,
                         input logic e_done);
    chk({tag, ".s_ready"}, 32'(s_ready), 32'(e_rdy));
    chk({tag, ".cs"},      32'(cs),      32'(e_cs));
    chk({tag, ".busy"},    32'(busy),    32'(e_busy));
    chk({tag, ".done"},    32'(done),    32'(e_done));
  endtask

  task automatic chk_wr(input string tag, input logic [11:0] ea,
                        input logic [7:0] ed);
    chk({tag, ".cs"},   32'(cs),      32'd1);
    chk({tag, ".addr"}, 32'(address), 32'(ea));
    chk({tag, ".data"}, 32'(data),    32'(ed));
  endtask

  // Full-rate burst with vblank held high; bytes are d0, d0+1, ...
  task automatic burst(input string tag, input logic [11:0] a,
                       input int n, input logic [7:0] d0);
    logic [11:0] ea;
    logic [7:0]  ed;
    start = 1'b1; start_addr = a; length = 13'(n);
    vblank = 1'b1; s_valid = 1'b0;
    @(negedge clk);
    chk_ctl({tag, ".idle"}, 1'b0, 1'b0, 1'b0, 1'b0);
    nxt();
    start = 1'b0; s_valid = 1'b1; s_data = d0;
    @(negedge clk);
    chk_ctl({tag, ".first"}, 1'b1, 1'b0, 1'b1, 1'b0);
    nxt();
    for (int i = 0; i < n; i++) begin
      s_data  = d0 + 8'(i + 1);
      s_valid = (i < n - 1);
      ea = a + 12'(i);
      ed = d0 + 8'(i);
      @(negedge clk);
      chk_wr($sformatf("%s.w%0d", tag, i), ea, ed);
      chk($sformatf("%s.rdy%0d", tag, i), 32'(s_ready),
          32'(i < n - 1));
      nxt();
    end
    s_valid = 1'b0;
    @(negedge clk);
    chk_ctl({tag, ".done"}, 1'b0, 1'b0, 1'b0, 1'b1);
    nxt();
    @(negedge clk);
    chk_ctl({tag, ".after"}, 1'b0, 1'b0, 1'b0, 1'b0);
    nxt();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start_addr = '0; length = '0;
    s_data = '0; s_valid = 1'b0; vblank = 1'b0;

    // reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      start      = 1'($urandom);
      start_addr = 12'($urandom);
      length     = 13'($urandom);
      s_data     = 8'($urandom);
      s_valid    = 1'($urandom);
      vblank     = 1'($urandom);
      @(negedge clk);
      chk_ctl($sformatf("rst%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("rst%0d.addr", i), 32'(address), 32'h0);
      chk($sformatf("rst%0d.data", i), 32'(data), 32'h0);
      nxt();
    end
    start = 1'b0; s_valid = 1'b0;
    rst = 1'b0;
    nxt();

    // basic four-byte burst
    burst("b4", 12'h100, 4, 8'hA0);

    // vblank gap after the second write
    start = 1'b1; start_addr = 12'h100; length = 13'd4; vblank = 1'b1;
    nxt();
    start = 1'b0; s_valid = 1'b1; s_data = 8'hA0;
    @(negedge clk);
    chk_ctl("vg.first", 1'b1, 1'b0, 1'b1, 1'b0);
    nxt();
    s_data = 8'hA1;
    @(negedge clk);
    chk_wr("vg.w0", 12'h100, 8'hA0);
    nxt();
    s_data = 8'hA2;
    @(negedge clk);
    chk_wr("vg.w1", 12'h101, 8'hA1);
    nxt();
    s_data = 8'hA3; vblank = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_ctl($sformatf("vg.low%0d", i), 1'b0, 1'b0, 1'b1, 1'b0);
      nxt();
    end
    vblank = 1'b1;
    @(negedge clk);
    chk_wr("vg.w2", 12'h102, 8'hA2);
    chk("vg.rdy2", 32'(s_ready), 32'd1);
    nxt();
    s_valid = 1'b0;
    @(negedge clk);
    chk_wr("vg.w3", 12'h103, 8'hA3);
    chk("vg.rdy3", 32'(s_ready), 32'd0);
    nxt();
    @(negedge clk);
    chk_ctl("vg.done", 1'b0, 1'b0, 1'b0, 1'b1);
    nxt();

    // address wrap at the top of VRAM
    burst("wrap", 12'hFFE, 4, 8'h50);

    // zero-length transfer
    start = 1'b1; start_addr = 12'h040; length = 13'd0;
    vblank = 1'b1; s_valid = 1'b0;
    nxt();
    start = 1'b0; s_valid = 1'b1; s_data = 8'h77;
    @(negedge clk);
    chk_ctl("z.xfer", 1'b0, 1'b0, 1'b1, 1'b0);
    nxt();
    @(negedge clk);
    chk_ctl("z.done", 1'b0, 1'b0, 1'b0, 1'b1);
    nxt();
    @(negedge clk);
    chk_ctl("z.after", 1'b0, 1'b0, 1'b0, 1'b0);
    s_valid = 1'b0;
    nxt();

    // restart ignored while busy, then reset mid-transfer
    start = 1'b1; start_addr = 12'h200; length = 13'd6; vblank = 1'b1;
    nxt();
    start_addr = 12'h300; s_valid = 1'b1; s_data = 8'hB0;
    @(negedge clk);
    chk_ctl("r.first", 1'b1, 1'b0, 1'b1, 1'b0);
    nxt();
    s_data = 8'hB1;
    @(negedge clk);
    chk_wr("r.w0", 12'h200, 8'hB0);
    nxt();
    start = 1'b0; s_data = 8'hB2;
    @(negedge clk);
    chk_wr("r.w1", 12'h201, 8'hB1);
    #1 rst = 1'b1;
    #1;
    chk_ctl("r.async", 1'b0, 1'b0, 1'b0, 1'b0);
    nxt();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_ctl($sformatf("r.post%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
      nxt();
    end
    s_valid = 1'b0;

    // writer recovers on the next start
    burst("again", 12'h010, 2, 8'hC0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
